// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencing and the IF/ID
// pipeline register feeding decode.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic [63:0] imem_adr,
  input  logic [31:0] imem_instr,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  localparam logic [63:0] LAST_PC = 64'(IMEM_SIZE) - 64'd4;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] target_aligned;
  logic        in_range;

  assign imem_adr       = pc;
  assign in_range       = (pc <= LAST_PC);
  assign target_aligned = redirect_target & ~64'd3;
  assign fetch_fault    = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ifid_pc     <= '0;
      ifid_instr  <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          ifid_valid <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          // Redirect wins over stall; the IF/ID payload is left as-is behind a bubble.
          if (redirect) begin
            pc         <= target_aligned;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            if (in_range) begin
              ifid_pc     <= pc;
              ifid_instr  <= imem_instr;
              ifid_valid  <= 1'b1;
              pc          <= pc + 64'd4;
              fetch_count <= fetch_count + 32'd1;
            end else begin
              ifid_valid <= 1'b0;
              state      <= HALT;
            end
          end
        end
        HALT: begin
          ifid_valid <= 1'b0;
          if (redirect) begin
            pc    <= target_aligned;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: each scenario pushes the expected
// post-edge outputs per cycle; a monitor pops and compares after every rising edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic [63:0] imem_adr;
  logic [31:0] imem_instr;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [31:0] cnt;
    logic        flt;
    logic [63:0] adr;
  } exp_t;

  exp_t sb[$];

  // Expected architectural state, advanced explicitly by each scenario.
  logic        e_v;
  logic [63:0] e_ipc;
  logic [31:0] e_ins;
  logic [31:0] e_cnt;
  logic        e_flt;
  logic [63:0] e_pc;

  instruction_fetch #(.RESET_PC(64'h0), .IMEM_SIZE(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_adr        (imem_adr),
    .imem_instr      (imem_instr),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int unsigned i);
    return 32'hC000_0013 | (32'(i) << 12);
  endfunction

  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_adr <= 64'd252) imem_instr = w(32'(imem_adr[7:2]));
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks += 6;
      if (ifid_valid !== e.v) begin
        errors++; $display("FAIL ifid_valid t=%0t got %0b exp %0b", $time, ifid_valid, e.v);
      end
      if (ifid_pc !== e.pc) begin
        errors++; $display("FAIL ifid_pc t=%0t got %h exp %h", $time, ifid_pc, e.pc);
      end
      if (ifid_instr !== e.ins) begin
        errors++; $display("FAIL ifid_instr t=%0t got %h exp %h", $time, ifid_instr, e.ins);
      end
      if (fetch_count !== e.cnt) begin
        errors++; $display("FAIL fetch_count t=%0t got %h exp %h", $time, fetch_count, e.cnt);
      end
      if (fetch_fault !== e.flt) begin
        errors++; $display("FAIL fetch_fault t=%0t got %0b exp %0b", $time, fetch_fault, e.flt);
      end
      if (imem_adr !== e.adr) begin
        errors++; $display("FAIL imem_adr t=%0t got %h exp %h", $time, imem_adr, e.adr);
      end
    end
  end

  task automatic push();
    exp_t e;
    e.v = e_v; e.pc = e_ipc; e.ins = e_ins; e.cnt = e_cnt; e.flt = e_flt; e.adr = e_pc;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    e_v = 1'b0; e_ipc = '0; e_ins = '0; e_cnt = '0; e_flt = 1'b0; e_pc = 64'h0;
  endtask

  // One ordinary fetch cycle: drive idle inputs, expect the current PC delivered.
  task automatic fetch_one();
    stall = 1'b0; redirect = 1'b0;
    e_ipc = e_pc; e_ins = w(32'(e_pc[7:2])); e_v = 1'b1;
    e_pc = e_pc + 64'd4; e_cnt = e_cnt + 32'd1;
    push();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks += 6;
    if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ifid_valid); end
    if (ifid_pc !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 0", ifid_pc); end
    if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", ifid_instr); end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", fetch_count); end
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fetch_fault); end
    if (imem_adr !== 64'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", imem_adr); end
    rst_n = 1'b1;
    push();  // BOOT cycle: bubble, PC held
    @(negedge clk);
  endtask

  task automatic test_run();
    for (int i = 0; i < 4; i++) fetch_one();
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (ifid_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0b exp 0", ifid_valid); end
    if (ifid_pc !== 64'h0) begin errors++; $display("FAIL async_ifid_pc got %h exp 0", ifid_pc); end
    if (ifid_instr !== 32'h0) begin errors++; $display("FAIL async_instr got %h exp 0", ifid_instr); end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL async_count got %h exp 0", fetch_count); end
    if (imem_adr !== 64'h0) begin errors++; $display("FAIL async_adr got %h exp 0", imem_adr); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    push();
    @(negedge clk);
    fetch_one();
    fetch_one();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push();
      @(negedge clk);
    end
    fetch_one();
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_target = 64'h0E;
    e_pc = 64'h0C; e_v = 1'b0;
    push();
    @(negedge clk);
    fetch_one();
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_target = 64'd244;
    e_pc = 64'd244; e_v = 1'b0;
    push();
    @(negedge clk);
    for (int i = 0; i < 3; i++) fetch_one();
    e_v = 1'b0; e_flt = 1'b1;
    push();
    @(negedge clk);
    stall = 1'b1;
    push();
    @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_target = 64'h0;
    e_pc = 64'h0; e_flt = 1'b0;
    push();
    @(negedge clk);
    fetch_one();
  endtask

  task automatic test_count_wrap();
    stall = 1'b1;
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1 release dut.fetch_count;
    e_cnt = 32'hFFFF_FFFF;
    push();
    @(negedge clk);
    fetch_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_async_reset();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_count_wrap();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
